// File: rtl/buddy_free_ctrl_if.sv
// buddy_free_ctrl_if: request/response bundle between the allocator clients and the buddy tree owner
interface buddy_free_ctrl_if;
  logic       alloc_valid;
  logic [5:0] alloc_addr;
  logic [2:0] alloc_order;
  logic       free_valid;
  logic [5:0] free_addr;
  logic [2:0] free_order;
  logic       req_ready;
  logic       done;
  logic       err;
  logic [5:0] merged_addr;
  logic [2:0] merged_order;
  logic [5:0] free_map;
  modport master(
    output alloc_valid, alloc_addr, alloc_order, free_valid, free_addr, free_order,
    input  req_ready, done, err, merged_addr, merged_order, free_map
  );
  modport slave(
    input  alloc_valid, alloc_addr, alloc_order, free_valid, free_addr, free_order,
    output req_ready, done, err, merged_addr, merged_order, free_map
  );
endinterface

// File: rtl/buddy_free_ctrl.sv
// buddy_free_ctrl: owns the 64-unit buddy tree, commits allocs, frees blocks and coalesces one level per cycle.
// Define BUDDY_FREE_CHECK_EN to reject illegal requests with err; otherwise requests are applied as given.
module buddy_free_ctrl (
  input logic              clk,
  input logic              rst,
  buddy_free_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;
  state_t      r_state, w_state_nxt;
  logic [63:0] r_alloc, r_split, w_alloc_nxt, w_split_nxt;
  logic [5:0]  r_cur_addr, w_cur_addr_nxt;
  logic [2:0]  r_cur_order, w_cur_order_nxt;
  logic        r_err, w_err_nxt;
  logic        w_alloc_ok, w_free_ok;
  logic [5:0]  w_bit, w_buddy, w_free_map;
  logic        w_buddy_free;
  // Nodes are packed order by order: order k starts at 64 - (64 >> k).
  function automatic logic [5:0] node_idx(input logic [5:0] addr, input logic [2:0] order);
    logic [2:0] k;
    k = order > 3'd5 ? 3'd5 : order;
    return 6'(7'd64 - (7'd64 >> k)) + (addr >> (k + 3'd1));
  endfunction
  function automatic logic [5:0] blk_mask(input logic [2:0] order);
    logic [6:0] m;
    m = (7'd2 << order) - 7'd1;
    return m[5:0];
  endfunction
`ifdef BUDDY_FREE_CHECK_EN
  always_comb begin
    w_alloc_ok = bus.alloc_order <= 3'd5 && (bus.alloc_addr & blk_mask(bus.alloc_order)) == 6'd0 &&
                 !r_alloc[node_idx(bus.alloc_addr, bus.alloc_order)] &&
                 !r_split[node_idx(bus.alloc_addr, bus.alloc_order)];
    for (int k = 1; k < 6; k++)
      if (3'(k) > bus.alloc_order && r_alloc[node_idx(bus.alloc_addr, 3'(k))]) w_alloc_ok = 1'b0;
    w_free_ok = bus.free_order <= 3'd5 && (bus.free_addr & blk_mask(bus.free_order)) == 6'd0 &&
                r_alloc[node_idx(bus.free_addr, bus.free_order)];
  end
`else
  assign w_alloc_ok = 1'b1;
  assign w_free_ok  = 1'b1;
`endif
  assign w_bit        = 6'(7'd2 << r_cur_order);
  assign w_buddy      = r_cur_addr ^ w_bit;
  assign w_buddy_free = !r_alloc[node_idx(w_buddy, r_cur_order)] && !r_split[node_idx(w_buddy, r_cur_order)];
  always_comb begin
    w_state_nxt     = r_state;
    w_alloc_nxt     = r_alloc;
    w_split_nxt     = r_split;
    w_cur_addr_nxt  = r_cur_addr;
    w_cur_order_nxt = r_cur_order;
    w_err_nxt       = r_err;
    case (r_state)
      IDLE: begin
        if (bus.alloc_valid) begin
          w_cur_addr_nxt  = bus.alloc_addr;
          w_cur_order_nxt = bus.alloc_order;
          w_err_nxt       = !w_alloc_ok;
          w_state_nxt     = RESP;
          if (w_alloc_ok) begin
            w_alloc_nxt[node_idx(bus.alloc_addr, bus.alloc_order)] = 1'b1;
            for (int k = 1; k < 6; k++)
              if (3'(k) > bus.alloc_order) w_split_nxt[node_idx(bus.alloc_addr, 3'(k))] = 1'b1;
          end
        end else if (bus.free_valid) begin
          w_cur_addr_nxt  = bus.free_addr;
          w_cur_order_nxt = bus.free_order;
          w_err_nxt       = !w_free_ok;
          w_state_nxt     = w_free_ok ? CHECK : RESP;
          if (w_free_ok) w_alloc_nxt[node_idx(bus.free_addr, bus.free_order)] = 1'b0;
        end
      end
      CHECK: begin
        if (r_cur_order >= 3'd5 || !w_buddy_free) begin
          w_state_nxt = RESP;
        end else begin
          w_split_nxt[node_idx(r_cur_addr, r_cur_order + 3'd1)] = 1'b0;
          w_cur_addr_nxt  = r_cur_addr & ~w_bit;
          w_cur_order_nxt = r_cur_order + 3'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // A node is available when free and its parent is split (the root needs no parent).
  always_comb begin
    w_free_map = '0;
    for (int k = 0; k < 6; k++)
      for (int n = 0; n < (32 >> k); n++)
        if (!r_alloc[node_idx(6'(n << (k + 1)), 3'(k))] && !r_split[node_idx(6'(n << (k + 1)), 3'(k))] &&
            (k == 5 || r_split[node_idx(6'(n << (k + 1)), 3'(k + 1))]))
          w_free_map[k] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_alloc     <= '0;
      r_split     <= '0;
      r_cur_addr  <= '0;
      r_cur_order <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_alloc     <= w_alloc_nxt;
      r_split     <= w_split_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_cur_order <= w_cur_order_nxt;
      r_err       <= w_err_nxt;
    end
  end
  assign bus.req_ready    = r_state == IDLE;
  assign bus.done         = r_state == RESP;
  assign bus.err          = r_err;
  assign bus.merged_addr  = r_cur_addr;
  assign bus.merged_order = r_cur_order;
  assign bus.free_map     = w_free_map;
endmodule

// File: tb/tb_buddy_free_ctrl.sv
// tb_buddy_free_ctrl: random and directed requests checked against a unit-occupancy model of the buddy allocator.
module tb_buddy_free_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  buddy_free_ctrl_if bus();
  buddy_free_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [63:0] used;
  logic [63:0] blk [6];
`ifdef BUDDY_FREE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  function automatic bit region_free(input int a, input int o);
    for (int u = a; u < a + (2 << o); u++) if (used[u]) return 1'b0;
    return 1'b1;
  endfunction
  // An empty block is available when it is the whole space or its parent region holds something.
  function automatic logic [5:0] model_map();
    logic [5:0] m = '0;
    for (int k = 0; k < 6; k++)
      for (int a = 0; a < 64; a += (2 << k))
        if (region_free(a, k) && (k == 5 || !region_free(a / (4 << k) * (4 << k), k + 1))) m[k] = 1'b1;
    return m;
  endfunction
  task automatic mark(input int a, input int o, input bit v);
    for (int u = a; u < a + (2 << o); u++) used[u] = v;
    blk[o][a] = v;
  endtask
  task automatic clear_model();
    used = '0;
    for (int k = 0; k < 6; k++) blk[k] = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
  endtask
  task automatic req(input bit is_alloc, input int a, input int o);
    bit legal;
    int ea, eo, lat, n;
    legal = o <= 5 && a % (2 << o) == 0;
    if (legal) legal = is_alloc ? region_free(a, o) : bit'(blk[o][a]);
    ea = a;
    eo = o;
    lat = 1;
    if (legal && is_alloc) mark(a, o, 1'b1);
    if (legal && !is_alloc) begin
      mark(a, o, 1'b0);
      while (eo < 5 && region_free(ea ^ (2 << eo), eo)) begin
        ea = ea & ~(2 << eo);
        eo++;
      end
      lat = eo - o + 2;
    end
    @(negedge clk);
    bus.alloc_valid = is_alloc;
    bus.free_valid  = !is_alloc;
    bus.alloc_addr  = 6'(a);
    bus.free_addr   = 6'(a);
    bus.alloc_order = 3'(o);
    bus.free_order  = 3'(o);
    @(posedge clk);
    #1;
    bus.alloc_valid = 1'b0;
    bus.free_valid  = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 12);
    chk(is_alloc ? "alloc_lat" : "free_lat", n, lat);
    chk("err", int'(bus.err), int'(CHK && !legal));
    if (legal) begin
      chk("merged_addr", int'(bus.merged_addr), ea);
      chk("merged_order", int'(bus.merged_order), eo);
    end
    chk("ready_busy", int'(bus.req_ready), 0);
    @(negedge clk);
    chk("ready_idle", int'(bus.req_ready), 1);
    chk("done_clear", int'(bus.done), 0);
    chk("free_map", int'(bus.free_map), int'(model_map()));
  endtask
  initial begin
    int dones;
    bus.alloc_valid = 1'b0;
    bus.free_valid  = 1'b0;
    bus.alloc_addr  = '0;
    bus.free_addr   = '0;
    bus.alloc_order = '0;
    bus.free_order  = '0;
    do_reset();
    chk("rst_map", int'(bus.free_map), 6'b100000);
    chk("rst_ready", int'(bus.req_ready), 1);
    chk("rst_done", int'(bus.done), 0);
    req(1'b1, 0, 0);
    chk("map_after_alloc", int'(bus.free_map), 6'b011111);
    req(1'b0, 0, 0);
    chk("map_after_free", int'(bus.free_map), 6'b100000);
    req(1'b1, 0, 0);
    req(1'b1, 2, 0);
    req(1'b0, 0, 0);
    req(1'b0, 2, 0);
`ifdef BUDDY_FREE_CHECK_EN
    req(1'b0, 8, 2);
    req(1'b0, 3, 1);
    req(1'b1, 0, 2);
    req(1'b1, 4, 1);
    req(1'b0, 0, 2);
`endif
    // Alloc and free presented together: alloc first, the held free right after RESP.
    req(1'b1, 0, 0);
    @(negedge clk);
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 6'd2;
    bus.alloc_order = 3'd0;
    bus.free_valid  = 1'b1;
    bus.free_addr   = 6'd0;
    bus.free_order  = 3'd0;
    @(posedge clk);
    #1;
    bus.alloc_valid = 1'b0;
    @(negedge clk);
    chk("both_alloc_done", int'(bus.done), 1);
    chk("both_alloc_addr", int'(bus.merged_addr), 2);
    @(negedge clk);
    chk("both_free_ready", int'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.free_valid = 1'b0;
    @(negedge clk);
    chk("both_free_busy", int'(bus.done), 0);
    @(negedge clk);
    chk("both_free_done", int'(bus.done), 1);
    chk("both_free_addr", int'(bus.merged_addr), 0);
    chk("both_free_order", int'(bus.merged_order), 0);
    mark(2, 0, 1'b1);
    mark(0, 0, 1'b0);
    req(1'b0, 2, 0);
    for (int i = 0; i < 300; i++) begin
      int o, a, r, fa, fo;
      bit found;
      r = $urandom_range(0, 9);
`ifdef BUDDY_FREE_CHECK_EN
      if (r == 0) begin
        req(1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 7));
        continue;
      end
`endif
      o = $urandom_range(0, 5);
      a = $urandom_range(0, 63) & ~((2 << o) - 1);
      found = 1'b0;
      fa = 0;
      fo = 0;
      for (int k = 0; k < 6 && !found; k++)
        for (int off = 0; off < 64 && !found; off++)
          if (blk[(k + r) % 6][(off + a) % 64]) begin
            found = 1'b1;
            fo = (k + r) % 6;
            fa = (off + a) % 64;
          end
      if (r < 5 && region_free(a, o)) req(1'b1, a, o);
      else if (found) req(1'b0, fa, fo);
      else if (region_free(a, o)) req(1'b1, a, o);
    end
    // Reset while coalescing must abort silently.
    do_reset();
    req(1'b1, 0, 0);
    @(negedge clk);
    bus.free_valid = 1'b1;
    bus.free_addr  = 6'd0;
    bus.free_order = 3'd0;
    @(posedge clk);
    #1;
    bus.free_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    chk("abort_ready", int'(bus.req_ready), 1);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_map", int'(bus.free_map), 6'b100000);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
